// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX pipeline stage: instruction type codes,
// bubble constants and operand-usage helpers.
package id_ex_stage_pkg;

  // Instruction type codes; R-type is the all-zero default.
  typedef enum logic [2:0] {
    R_TYPE     = 3'd0,
    IMM_I_TYPE = 3'd1,
    IMM_S_TYPE = 3'd2,
    IMM_B_TYPE = 3'd3,
    IMM_U_TYPE = 3'd4,
    IMM_J_TYPE = 3'd5
  } instr_type_e;

  // Control bits carried through the stage.
  typedef struct packed {
    logic valid;
    logic rd_write;
    logic mem_read;
    logic mem_write;
    logic jump;
  } ctrl_t;

  // Bubble contents: no control, register indices that never match a forward.
  localparam ctrl_t      BUBBLE_CTRL = '0;
  localparam logic [4:0] BUBBLE_REG  = 5'd0;
  localparam logic [2:0] BUBBLE_TYPE = 3'd0;

  // U and J formats carry no rs1 operand.
  function automatic logic type_uses_rs1(input logic [2:0] t);
    return !((t == IMM_U_TYPE) || (t == IMM_J_TYPE));
  endfunction

  // I, U and J formats carry no rs2 operand.
  function automatic logic type_uses_rs2(input logic [2:0] t);
    return !((t == IMM_I_TYPE) || (t == IMM_U_TYPE) || (t == IMM_J_TYPE));
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Bus between the decode side, the ID/EX register and the execute side.
interface id_ex_stage_if #(
  parameter int XLEN = 32
);
  logic            id_valid;
  logic [XLEN-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]      id_rs1, id_rs2, id_rd;
  logic [2:0]      id_instr_type;
  logic            id_rd_write, id_mem_read, id_mem_write, id_jump;
  logic            flush_in, hold_in;

  logic            ex_valid;
  logic [XLEN-1:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]      ex_rs1, ex_rs2, ex_rd;
  logic [2:0]      ex_instr_type;
  logic            ex_rd_write, ex_mem_read, ex_mem_write, ex_jump;
  logic            stall_out;

  // Upstream driver: supplies the decoded instruction and pipeline controls.
  modport master (
    output id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2,
           id_rd, id_instr_type, id_rd_write, id_mem_read, id_mem_write, id_jump,
           flush_in, hold_in,
    input  ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2,
           ex_rd, ex_instr_type, ex_rd_write, ex_mem_read, ex_mem_write, ex_jump,
           stall_out
  );

  // The stage register itself.
  modport slave (
    input  id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2,
           id_rd, id_instr_type, id_rd_write, id_mem_read, id_mem_write, id_jump,
           flush_in, hold_in,
    output ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2,
           ex_rd, ex_instr_type, ex_rd_write, ex_mem_read, ex_mem_write, ex_jump,
           stall_out
  );
endinterface

// File: rtl/id_ex_stage_hazard_detect.sv
// Combinational load-use hazard detection between the EX load and the ID instruction.
module id_ex_stage_hazard_detect
  import id_ex_stage_pkg::*;
(
  input  logic       ex_valid,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic [2:0] id_instr_type,
  output logic       uses_rs1,
  output logic       uses_rs2,
  output logic       lu
);
  // A load into x0 never creates a dependency.
  always_comb begin
    uses_rs1 = type_uses_rs1(id_instr_type);
    uses_rs2 = type_uses_rs2(id_instr_type);
    lu = ex_valid && ex_mem_read && (ex_rd != 5'd0) && id_valid &&
         ((uses_rs1 && (ex_rd == id_rs1)) || (uses_rs2 && (ex_rd == id_rs2)));
  end
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, flush bubbles, hold and
// saturating bubble counters.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  id_ex_stage_if.slave     bus,
  output logic [CNT_W-1:0] load_use_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  ctrl_t            ctrl_q, ctrl_d;
  logic [XLEN-1:0]  pc_q, pc_d, rs1_data_q, rs1_data_d, rs2_data_q, rs2_data_d, imm_q, imm_d;
  logic [4:0]       rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic [2:0]       type_q, type_d;
  logic [CNT_W-1:0] lu_cnt_q, lu_cnt_d, fl_cnt_q, fl_cnt_d;
  logic             lu, uses_rs1, uses_rs2;

  id_ex_stage_hazard_detect u_hazard (
    .ex_valid      (ctrl_q.valid),
    .ex_mem_read   (ctrl_q.mem_read),
    .ex_rd         (rd_q),
    .id_valid      (bus.id_valid),
    .id_rs1        (bus.id_rs1),
    .id_rs2        (bus.id_rs2),
    .id_instr_type (bus.id_instr_type),
    .uses_rs1      (uses_rs1),
    .uses_rs2      (uses_rs2),
    .lu            (lu)
  );

  // A flush or hold overrides the stall: the ID instruction is discarded or frozen anyway.
  assign bus.stall_out = lu && !bus.flush_in && !bus.hold_in;

  // Next-state selection: hold > flush bubble > load-use bubble > pass-through.
  always_comb begin
    ctrl_d = ctrl_q;  pc_d = pc_q;  rs1_data_d = rs1_data_q;  rs2_data_d = rs2_data_q;
    imm_d = imm_q;    rs1_d = rs1_q; rs2_d = rs2_q;  rd_d = rd_q;  type_d = type_q;
    lu_cnt_d = lu_cnt_q;
    fl_cnt_d = fl_cnt_q;
    if (!bus.hold_in) begin
      if (bus.flush_in || lu) begin
        ctrl_d = BUBBLE_CTRL; pc_d = '0; rs1_data_d = '0; rs2_data_d = '0; imm_d = '0;
        rs1_d = BUBBLE_REG;   rs2_d = BUBBLE_REG; rd_d = BUBBLE_REG; type_d = BUBBLE_TYPE;
        if (bus.flush_in) begin
          if (!(&fl_cnt_q)) fl_cnt_d = fl_cnt_q + CNT_ONE;
        end else begin
          if (!(&lu_cnt_q)) lu_cnt_d = lu_cnt_q + CNT_ONE;
        end
      end else begin
        pc_d = bus.id_pc;  rs1_data_d = bus.id_rs1_data;  rs2_data_d = bus.id_rs2_data;
        imm_d = bus.id_imm; rs1_d = bus.id_rs1; rs2_d = bus.id_rs2; rd_d = bus.id_rd;
        type_d = bus.id_instr_type;
        // An empty ID slot must never leak control into EX.
        ctrl_d.valid     = bus.id_valid;
        ctrl_d.rd_write  = bus.id_valid && bus.id_rd_write;
        ctrl_d.mem_read  = bus.id_valid && bus.id_mem_read;
        ctrl_d.mem_write = bus.id_valid && bus.id_mem_write;
        ctrl_d.jump      = bus.id_valid && bus.id_jump;
      end
    end
  end

  // Stage and counter registers, cleared immediately on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q <= BUBBLE_CTRL; pc_q <= '0; rs1_data_q <= '0; rs2_data_q <= '0; imm_q <= '0;
      rs1_q <= '0; rs2_q <= '0; rd_q <= '0; type_q <= BUBBLE_TYPE;
      lu_cnt_q <= '0; fl_cnt_q <= '0;
    end else begin
      ctrl_q <= ctrl_d; pc_q <= pc_d; rs1_data_q <= rs1_data_d; rs2_data_q <= rs2_data_d;
      imm_q <= imm_d; rs1_q <= rs1_d; rs2_q <= rs2_d; rd_q <= rd_d; type_q <= type_d;
      lu_cnt_q <= lu_cnt_d; fl_cnt_q <= fl_cnt_d;
    end
  end

  assign bus.ex_valid      = ctrl_q.valid;
  assign bus.ex_rd_write   = ctrl_q.rd_write;
  assign bus.ex_mem_read   = ctrl_q.mem_read;
  assign bus.ex_mem_write  = ctrl_q.mem_write;
  assign bus.ex_jump       = ctrl_q.jump;
  assign bus.ex_pc         = pc_q;
  assign bus.ex_rs1_data   = rs1_data_q;
  assign bus.ex_rs2_data   = rs2_data_q;
  assign bus.ex_imm        = imm_q;
  assign bus.ex_rs1        = rs1_q;
  assign bus.ex_rs2        = rs2_q;
  assign bus.ex_rd         = rd_q;
  assign bus.ex_instr_type = type_q;
  assign load_use_cnt      = lu_cnt_q;
  assign flush_cnt         = fl_cnt_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: an independent reference model predicts the
// EX register and counters for every edge; predictions are queued and compared.
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc, rs1_data, rs2_data, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  typ;
    logic        rd_write, mem_read, mem_write, jump;
    logic [15:0] lu_cnt, fl_cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] load_use_cnt, flush_cnt;
  int vectors = 0;
  int miscompares = 0;
  exp_t m;
  exp_t sb_q[$];

  id_ex_stage_if #(.XLEN(32)) bus ();

  id_ex_stage #(.XLEN(32), .CNT_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .load_use_cnt (load_use_cnt),
    .flush_cnt    (flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t observe();
    exp_t o;
    o.valid = bus.ex_valid; o.pc = bus.ex_pc; o.rs1_data = bus.ex_rs1_data;
    o.rs2_data = bus.ex_rs2_data; o.imm = bus.ex_imm; o.rs1 = bus.ex_rs1;
    o.rs2 = bus.ex_rs2; o.rd = bus.ex_rd; o.typ = bus.ex_instr_type;
    o.rd_write = bus.ex_rd_write; o.mem_read = bus.ex_mem_read;
    o.mem_write = bus.ex_mem_write; o.jump = bus.ex_jump;
    o.lu_cnt = load_use_cnt; o.fl_cnt = flush_cnt;
    return o;
  endfunction

  function automatic logic needs_rs1(input logic [2:0] t);
    return (t != 3'd4) && (t != 3'd5);
  endfunction
  function automatic logic needs_rs2(input logic [2:0] t);
    return (t == 3'd0) || (t == 3'd2) || (t == 3'd3) || (t == 3'd6) || (t == 3'd7);
  endfunction

  task automatic set_id(input logic v, input logic [2:0] t, input logic [4:0] r1,
                        input logic [4:0] r2, input logic [4:0] rd, input logic rdw,
                        input logic mr, input logic mw, input logic j,
                        input logic fl, input logic hd);
    bus.id_valid = v; bus.id_instr_type = t; bus.id_rs1 = r1; bus.id_rs2 = r2; bus.id_rd = rd;
    bus.id_rd_write = rdw; bus.id_mem_read = mr; bus.id_mem_write = mw; bus.id_jump = j;
    bus.id_pc = $urandom; bus.id_rs1_data = $urandom; bus.id_rs2_data = $urandom;
    bus.id_imm = $urandom; bus.flush_in = fl; bus.hold_in = hd;
  endtask

  // One clock: check stall, predict next EX state, push, clock, pop and compare.
  task automatic step();
    logic lu_e;
    exp_t e;
    #1;
    lu_e = m.valid && m.mem_read && (m.rd != 5'd0) && bus.id_valid &&
           ((needs_rs1(bus.id_instr_type) && m.rd == bus.id_rs1) ||
            (needs_rs2(bus.id_instr_type) && m.rd == bus.id_rs2));
    chk("stall_out", 256'(bus.stall_out), 256'(lu_e && !bus.flush_in && !bus.hold_in));
    if (!bus.hold_in) begin
      if (bus.flush_in || lu_e) begin
        m = '{lu_cnt: m.lu_cnt, fl_cnt: m.fl_cnt, default: '0};
        if (bus.flush_in) begin
          if (m.fl_cnt != 16'hFFFF) m.fl_cnt = m.fl_cnt + 16'd1;
        end else if (m.lu_cnt != 16'hFFFF) m.lu_cnt = m.lu_cnt + 16'd1;
      end else begin
        m.valid = bus.id_valid; m.pc = bus.id_pc; m.rs1_data = bus.id_rs1_data;
        m.rs2_data = bus.id_rs2_data; m.imm = bus.id_imm; m.rs1 = bus.id_rs1;
        m.rs2 = bus.id_rs2; m.rd = bus.id_rd; m.typ = bus.id_instr_type;
        m.rd_write = bus.id_valid & bus.id_rd_write; m.mem_read = bus.id_valid & bus.id_mem_read;
        m.mem_write = bus.id_valid & bus.id_mem_write; m.jump = bus.id_valid & bus.id_jump;
      end
    end
    sb_q.push_back(m);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk("ex_state", 256'(observe()), 256'(e));
  endtask

  // Put a valid load writing rd into EX.
  task automatic load_into_ex(input logic [4:0] rd);
    set_id(1, 3'd1, 5'd1, 5'd0, rd, 1, 1, 0, 0, 0, 0);
    step();
  endtask

  initial begin
    exp_t snap;
    m = '0;
    set_id(0, 3'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #12;
    chk("reset_state", 256'(observe()), 256'(exp_t'('0)));
    chk("reset_stall", 256'(bus.stall_out), 256'(0));
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Load-use: R-type reading the load result through rs2.
    load_into_ex(5'd5);
    set_id(1, 3'd0, 5'd3, 5'd5, 5'd9, 1, 0, 0, 0, 0, 0);
    #1 chk("lu_stall_hi", 256'(bus.stall_out), 256'(1));
    step();
    chk("lu_bubble_valid", 256'(bus.ex_valid), 256'(0));
    chk("lu_bubble_rd", 256'(bus.ex_rd), 256'(0));
    chk("lu_cnt_one", 256'(load_use_cnt), 256'(1));
    #1 chk("lu_stall_lo", 256'(bus.stall_out), 256'(0));
    step();
    chk("lu_pass_rd", 256'(bus.ex_rd), 256'(9));

    // Unused rs2 on I-type, and a load into x0, must not stall.
    load_into_ex(5'd5);
    set_id(1, 3'd1, 5'd7, 5'd5, 5'd2, 1, 0, 0, 0, 0, 0);
    step();
    load_into_ex(5'd0);
    set_id(1, 3'd0, 5'd0, 5'd0, 5'd2, 1, 0, 0, 0, 0, 0);
    step();

    // Flush wins over load-use.
    load_into_ex(5'd5);
    set_id(1, 3'd0, 5'd5, 5'd6, 5'd8, 1, 0, 0, 0, 1, 0);
    step();
    chk("flush_cnt_one", 256'(flush_cnt), 256'(1));
    chk("flush_lu_cnt", 256'(load_use_cnt), 256'(1));

    // Hold for three cycles with flush pending, then flush applies.
    load_into_ex(5'd12);
    snap = observe();
    for (int i = 0; i < 3; i++) begin
      set_id(1, 3'd0, 5'd12, 5'd12, 5'd3, 1, 0, 0, 0, 1, 1);
      step();
    end
    chk("hold_frozen", 256'(observe()), 256'(snap));
    set_id(1, 3'd0, 5'd12, 5'd12, 5'd3, 1, 0, 0, 0, 1, 0);
    step();
    chk("post_hold_flush", 256'(flush_cnt), 256'(2));

    // Empty ID slot with control inputs asserted.
    set_id(0, 3'd0, 5'd4, 5'd4, 5'd4, 1, 1, 1, 1, 0, 0);
    step();
    chk("invalid_ctrl", 256'({bus.ex_valid, bus.ex_rd_write, bus.ex_mem_read,
                               bus.ex_mem_write, bus.ex_jump}), 256'(0));

    // Random traffic with small register indices to provoke hazards.
    for (int i = 0; i < 300; i++) begin
      set_id(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
             5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
             1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 9) == 0));
      step();
    end

    // Asynchronous reset mid-run with a pending load-use.
    load_into_ex(5'd5);
    set_id(1, 3'd0, 5'd5, 5'd0, 5'd1, 1, 0, 0, 0, 0, 0);
    rst = 1'b1;
    #2;
    chk("midrun_reset", 256'(observe()), 256'(exp_t'('0)));
    chk("midrun_reset_stall", 256'(bus.stall_out), 256'(0));
    m = '0;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    set_id(1, 3'd0, 5'd5, 5'd0, 5'd1, 1, 0, 0, 0, 0, 0);
    step();

    // Saturation of the load-use counter.
    force dut.lu_cnt_q = 16'hFFFE;
    #1 release dut.lu_cnt_q;
    m.lu_cnt = 16'hFFFE;
    for (int i = 0; i < 3; i++) begin
      load_into_ex(5'd7);
      set_id(1, 3'd0, 5'd7, 5'd1, 5'd1, 1, 0, 0, 0, 0, 0);
      step();
    end
    chk("lu_cnt_saturated", 256'(load_use_cnt), 256'(16'hFFFF));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
